pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage. Holds the program counter, issues word fetches to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register.
- IfIdPcP4 travels down the pipeline and becomes the PcP4 input of the branch-resolution stage.
- That stage returns its selected next PC on NextPc, with Redirect = Branch & ZeroFlag.
- Handles stalls through a one-entry skid buffer and branch redirects, including a redirect that arrives while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on reset or flush.

Ports:
- Clk  input  1  single clock, all state on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- NextPc  input  32  redirect target from the branch-resolution stage.
- Redirect  input  1  taken branch. Load NextPc and flush IF/ID.
- Stall  input  1  hazard stall. IF/ID must hold.
- IMemReq  output  1  fetch request.
- IMemAddr  output  32  fetch address. Word aligned.
- IMemReady  input  1  memory accepts; IMemRdata is valid this same cycle.
- IMemRdata  input  32  fetched instruction.
- FetchPc  output  32  current PC register.
- IfIdInstr  output  32  IF/ID instruction.
- IfIdPcP4  output  32  IF/ID PC+4 of that instruction.
- IfIdValid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset: Rst high at a posedge sets the following:
  - Pc = RESET_PC; state = IDLE.
  - IMemReq = 0; skid buffer empty.
  - IfIdInstr = NOP_INSTR; IfIdPcP4 = 0; IfIdValid = 0.
  - Rst takes effect mid-transaction too: a pending response is abandoned and a late IMemReady is ignored.
- States: IDLE, FETCH, HOLD, DRAIN. IMemReq = 1 in FETCH and DRAIN only.
- IDLE: goes to FETCH after 1 cycle. The first request therefore appears in the 2nd cycle after Rst deasserts.
- FETCH: IMemAddr = Pc. IMemAddr must stay stable while IMemReq & !IMemReady.
  - Ready & !Redirect & !Stall: IF/ID <= {IMemRdata, Pc+4, valid=1}; Pc <= Pc+4; stay in FETCH. Throughput is 1 instruction/cycle when Ready is held high.
  - Ready & !Redirect & Stall: skid <= {IMemRdata, Pc+4}; Pc <= Pc+4; IF/ID holds; go to HOLD.
  - Ready & Redirect: discard IMemRdata; Pc <= NextPc; flush IF/ID; stay in FETCH.
  - !Ready & Redirect: RedirPc <= NextPc; flush IF/ID; go to DRAIN.
  - !Ready & !Redirect: hold everything. Stall is irrelevant.
- HOLD: IMemReq = 0.
  - !Stall: IF/ID <= {skid, valid=1}; go to FETCH.
  - Redirect (any Stall value): drop skid; Pc <= NextPc; flush IF/ID; go to FETCH.
- DRAIN: IMemAddr keeps the old Pc until the response arrives.
  - Redirect without Ready: RedirPc <= NextPc (last redirect wins).
  - Ready: discard the data; Pc <= (Redirect ? NextPc : RedirPc); go to FETCH.
- Flush: IfIdValid <= 0 and IfIdInstr <= NOP_INSTR. IfIdPcP4 is don't-care and held.
- Priority: Rst > Redirect > Stall.
- Stall with no new data: IF/ID holds all fields.
- Arithmetic: Pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Alignment: NextPc[1:0] is forced to 0 when loaded; RESET_PC[1:0] is required to be 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, three output ports are added:
  - StallCycles[31:0]: +1 per cycle with Stall & IfIdValid.
  - FlushCount[31:0]: +1 per cycle with Redirect.
  - FetchCount[31:0]: +1 per accepted, non-discarded response.
- All three counters clear on Rst and wrap at 2^32.
- When undefined, the ports and logic are absent; functionality is otherwise identical.

Test Plan:
- Reset, Ready tied high, words 0x11,0x22,0x33 at addresses 0,4,8 -> IMemAddr 0,4,8 on consecutive cycles. IF/ID shows {0x11,4},{0x22,8},{0x33,12}, IfIdValid=1 from cycle 3.
- Stall for 3 cycles while the response for addr 8 arrives -> IF/ID holds {0x22,8}. IMemReq=0 in HOLD. After Stall drops, IF/ID = {0x33,12} and the next fetch is addr 12.
- Redirect with NextPc=0x100 while Ready=1 at addr 0x10 -> data dropped, IfIdValid=0 and IfIdInstr=NOP_INSTR next cycle, next IMemAddr=0x100.
- Ready low for 4 cycles at addr 0x20, Redirect (NextPc=0x200) in cycle 1 and again (NextPc=0x300) in cycle 3:
  - IMemAddr stays 0x20 until Ready, and that response is dropped.
  - Next IMemAddr = 0x300.
- Pc=0xFFFF_FFFC fetched -> IfIdPcP4=0 and next IMemAddr=0. Rst asserted while in DRAIN -> next request is to RESET_PC and the stale Ready response is ignored.
- With FETCH_PERF_CNT_EN: 5 fetches, 2 stall cycles, 1 redirect -> FetchCount=5, StallCycles=2, FlushCount=1. Rst clears all three to 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ready fetch FSM, one-entry skid buffer and IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] NextPc,
    input  logic        Redirect,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRdata,
    output logic [31:0] FetchPc,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPcP4,
    output logic        IfIdValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount,
    output logic [31:0] FetchCount
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pcp4_q, skid_pcp4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        accept;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = {NextPc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;
        instr_d      = instr_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        IMemReq      = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (Redirect) pc_d = target;
            end
            StFetch: begin
                IMemReq = 1'b1;
                if (IMemReady) begin
                    if (Redirect) begin
                        pc_d = target;
                    end else begin
                        accept = 1'b1;
                        pc_d   = pc_plus4;
                        if (Stall) begin
                            skid_instr_d = IMemRdata;
                            skid_pcp4_d  = pc_plus4;
                            state_d      = StHold;
                        end else begin
                            instr_d = IMemRdata;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                        end
                    end
                end else if (Redirect) begin
                    // Response still owed for pc_q; park the target until it arrives.
                    redir_pc_d = target;
                    state_d    = StDrain;
                end
            end
            StHold: begin
                if (Redirect) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!Stall) begin
                    instr_d = skid_instr_q;
                    pcp4_d  = skid_pcp4_q;
                    valid_d = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                IMemReq = 1'b1;
                if (IMemReady) begin
                    pc_d    = Redirect ? target : redir_pc_q;
                    state_d = StFetch;
                end else if (Redirect) begin
                    redir_pc_d = target;
                end
            end
        endcase

        // Any redirect kills the IF/ID entry; PC+4 field is left as is.
        if (Redirect) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pcp4_q  <= 32'd0;
            instr_q      <= NOP_INSTR;
            pcp4_q       <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
            instr_q      <= instr_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign IMemAddr  = pc_q;
    assign FetchPc   = pc_q;
    assign IfIdInstr = instr_q;
    assign IfIdPcP4  = pcp4_q;
    assign IfIdValid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, fetch_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            if (Stall && valid_q) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (Redirect)         flush_cnt_q <= flush_cnt_q + 32'd1;
            if (accept)           fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
    assign FetchCount  = fetch_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: streaming, stall/skid, redirects, drain, wrap and reset.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] NextPc;
    logic        Redirect;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRdata;
    logic [31:0] FetchPc;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPcP4;
    logic        IfIdValid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount, FetchCount;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    pc_fetch_unit dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .NextPc    (NextPc),
        .Redirect  (Redirect),
        .Stall     (Stall),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemReady (IMemReady),
        .IMemRdata (IMemRdata),
        .FetchPc   (FetchPc),
        .IfIdInstr (IfIdInstr),
        .IfIdPcP4  (IfIdPcP4),
        .IfIdValid (IfIdValid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount),
        .FetchCount  (FetchCount)
`endif
    );

    always #5 Clk = ~Clk;

    // Tiny instruction memory: three known words, a recognisable pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return addr ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign IMemRdata = mem_word(IMemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1; IMemReady = 1'b1; Stall = 1'b0; Redirect = 1'b0; NextPc = 32'h0;
        tick();
        check("rst_req",   IMemReq,   0);
        check("rst_valid", IfIdValid, 0);
        check("rst_instr", IfIdInstr, 32'h0);
        check("rst_pcp4",  IfIdPcP4,  32'h0);
        check("rst_pc",    FetchPc,   32'h0);
        Rst = 1'b0;
        check("idle_req",  IMemReq,   0);

        // Streaming fetch with Ready held high
        tick();
        check("f0_req",  IMemReq,  1);
        check("f0_addr", IMemAddr, 32'h0);
        tick();
        check("f1_addr",  IMemAddr,  32'h4);
        check("f1_instr", IfIdInstr, 32'h11);
        check("f1_pcp4",  IfIdPcP4,  32'h4);
        check("f1_valid", IfIdValid, 1);
        tick();
        check("f2_addr",  IMemAddr,  32'h8);
        check("f2_instr", IfIdInstr, 32'h22);
        check("f2_pcp4",  IfIdPcP4,  32'h8);

        // Stall three cycles while the addr 8 response lands in the skid
        Stall = 1'b1;
        tick();
        check("hold_req",   IMemReq,   0);
        check("hold_instr", IfIdInstr, 32'h22);
        tick();
        tick();
        check("hold3_req",   IMemReq,   0);
        check("hold3_instr", IfIdInstr, 32'h22);
        check("hold3_pcp4",  IfIdPcP4,  32'h8);
        Stall = 1'b0;
        tick();
        check("unskid_instr", IfIdInstr, 32'h33);
        check("unskid_pcp4",  IfIdPcP4,  32'hC);
        check("unskid_valid", IfIdValid, 1);
        check("unskid_req",   IMemReq,   1);
        check("unskid_addr",  IMemAddr,  32'hC);
        tick();
        check("f3_instr", IfIdInstr, 32'hA5A5_000C);
        check("f3_addr",  IMemAddr,  32'h10);

        // Redirect coinciding with Ready
        Redirect = 1'b1; NextPc = 32'h100;
        tick();
        check("redir_valid", IfIdValid, 0);
        check("redir_instr", IfIdInstr, 32'h0);
        check("redir_pcp4",  IfIdPcP4,  32'h10);
        check("redir_addr",  IMemAddr,  32'h100);
        // Misaligned target is forced to word alignment
        NextPc = 32'h22;
        tick();
        check("align_addr", IMemAddr, 32'h20);

        // Ready low for four cycles with two redirects; last one wins
        IMemReady = 1'b0; Redirect = 1'b1; NextPc = 32'h200;
        tick();
        check("drain1_req",  IMemReq,  1);
        check("drain1_addr", IMemAddr, 32'h20);
        Redirect = 1'b0;
        tick();
        check("drain2_addr", IMemAddr, 32'h20);
        Redirect = 1'b1; NextPc = 32'h300;
        tick();
        check("drain3_addr", IMemAddr, 32'h20);
        Redirect = 1'b0;
        tick();
        check("drain4_addr",  IMemAddr,  32'h20);
        check("drain4_valid", IfIdValid, 0);
        IMemReady = 1'b1;
        tick();
        check("drain_done_addr",  IMemAddr,  32'h300);
        check("drain_done_valid", IfIdValid, 0);

        // PC+4 wrap at the top of the address space
        Redirect = 1'b1; NextPc = 32'hFFFF_FFFC;
        tick();
        check("wrap_addr0", IMemAddr, 32'hFFFF_FFFC);
        Redirect = 1'b0;
        tick();
        check("wrap_pcp4",  IfIdPcP4,  32'h0);
        check("wrap_instr", IfIdInstr, 32'h5A5A_FFFC);
        check("wrap_valid", IfIdValid, 1);
        check("wrap_addr1", IMemAddr,  32'h0);

        // Reset while in DRAIN; stale Ready afterwards must be ignored
        IMemReady = 1'b0; Redirect = 1'b1; NextPc = 32'h400;
        tick();
        check("pre_rst_req",  IMemReq,  1);
        check("pre_rst_addr", IMemAddr, 32'h0);
        Redirect = 1'b0; Rst = 1'b1;
        tick();
        check("mid_rst_req",   IMemReq,   0);
        check("mid_rst_pc",    FetchPc,   32'h0);
        check("mid_rst_valid", IfIdValid, 0);
        Rst = 1'b0; IMemReady = 1'b1;
        tick();
        check("post_rst_req",   IMemReq,   1);
        check("post_rst_addr",  IMemAddr,  32'h0);
        check("post_rst_valid", IfIdValid, 0);
        tick();
        check("post_rst_addr1", IMemAddr,  32'h4);
        check("post_rst_instr", IfIdInstr, 32'h11);

`ifdef FETCH_PERF_CNT_EN
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("cnt_rst_fetch", FetchCount,  32'd0);
        check("cnt_rst_stall", StallCycles, 32'd0);
        check("cnt_rst_flush", FlushCount,  32'd0);
        tick();
        tick();
        tick();
        tick();
        Stall = 1'b1;
        tick();
        tick();
        Stall = 1'b0;
        tick();
        tick();
        IMemReady = 1'b0; Redirect = 1'b1; NextPc = 32'h40;
        tick();
        Redirect = 1'b0;
        check("cnt_fetch", FetchCount,  32'd5);
        check("cnt_stall", StallCycles, 32'd2);
        check("cnt_flush", FlushCount,  32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("cnt_clr_fetch", FetchCount,  32'd0);
        check("cnt_clr_stall", StallCycles, 32'd0);
        check("cnt_clr_flush", FlushCount,  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
